beta_dmem_ctrl: RTL and testbench
=================================

BETA_DMEM_CTRL -- requirements
Module: beta_dmem_ctrl

Interface
REQ-001 The block SHALL have a parameter DataWidth, default 32, giving the data bus width; only 32 is supported.
REQ-002 The block SHALL have a parameter AddressWidth, default 32, giving the byte address width.
REQ-003 The block SHALL have a parameter WaitStates, default 0, giving the extra cycles inserted before each SRAM access.
REQ-004 The block SHALL have a parameter MemWords, default 1024, giving the SRAM depth in words.
REQ-005 The block SHALL have one clock; reset SHALL be synchronous and active-high.
REQ-006 The block SHALL provide these ports:
- clk_i  in  1  clock
- rst_i  in  1  synchronous active-high reset
- rdata_req_i  in  1  load request
- rdata_addr_i  in  AddressWidth  load byte address
- rdata_strb_i  in  4  low-aligned lane mask (0001/0011/1111)
- rdata_ready_o  out  1  load accepted, one-cycle pulse
- rdata_valid_o  out  1  load done, one-cycle pulse
- rdata_data_o  out  DataWidth  load data, right-aligned
- wdata_req_i  in  1  store request
- wdata_addr_i  in  AddressWidth  store byte address
- wdata_data_i  in  DataWidth  store data, right-aligned
- wdata_strb_i  in  4  low-aligned lane mask
- wdata_ready_o  out  1  store accepted, one-cycle pulse
- wdata_valid_o  out  1  store done, one-cycle pulse
- dmem_err_o  out  1  access error, pulses with valid
- mem_en_o  out  1  SRAM enable
- mem_we_o  out  1  SRAM write enable
- mem_addr_o  out  log2(MemWords)  SRAM word address
- mem_be_o  out  4  SRAM byte enables
- mem_wdata_o  out  DataWidth  SRAM write data
- mem_rdata_i  in  DataWidth  SRAM read data, valid one cycle after mem_en_o

Function
REQ-007 The FSM SHALL have states IDLE, WAIT, MEM and RESP.
REQ-008 In IDLE with a request pending, the block SHALL latch op, addr, strb and data, pulse the matching ready_o in the next cycle, load the counter with WaitStates, and go to WAIT.
REQ-009 If both requests are pending in IDLE, the store SHALL be accepted first and the load left pending.
REQ-010 Requests SHALL be ignored outside IDLE; a req still high during the ready cycle SHALL NOT be accepted twice.
REQ-011 In WAIT, the counter SHALL decrement while it is nonzero; at zero the FSM SHALL go to MEM, or to RESP if the error flag is set.
REQ-012 Error flag: it SHALL be set when (strb << addr[1:0]) has bits above lane 3, or when addr[AddressWidth-1:2] >= MemWords.
REQ-013 In MEM, the block SHALL assert mem_en_o (Moore decode) and drive mem_we_o = store, mem_addr_o = addr[..:2], mem_be_o = (strb << addr[1:0])[3:0] and mem_wdata_o = data << 8*addr[1:0]; the FSM SHALL then go to RESP.
REQ-014 In RESP, the block SHALL register the matching valid_o for one cycle; for a load, rdata_data_o = (mem_rdata_i >> 8*addr[1:0]) with non-strobed lanes zeroed (no sign extension).
REQ-015 On error, the block SHALL return rdata_data_o = 0 with dmem_err_o high for the valid cycle and SHALL NOT assert mem_en_o.
REQ-016 Latency SHALL be: ready in cycle k, mem_en_o in cycle k+1+WaitStates, valid in cycle k+3+WaitStates.
REQ-017 The FSM SHALL be in IDLE during the valid cycle, so back-to-back acceptance is allowed.
REQ-018 rdata_data_o SHALL hold its value until the next load completes.
REQ-019 All outputs except mem_* SHALL be registered; mem_* SHALL be 0 outside MEM.

Reset
REQ-020 On rst_i, the block SHALL set state to IDLE, clear the counter and latches, and drive all outputs to 0, including rdata_data_o.
REQ-021 A reset mid-transaction SHALL drop the transaction without a valid pulse or a memory write.

Structure
REQ-022 State encodings (DMEM_IDLE, DMEM_WAIT, DMEM_MEM, DMEM_RESP) and dmem_fsm_bsize SHALL live in beta_pkg.
REQ-023 Lane shifting, masking and the error check SHALL be one combinational sub-module, beta_dmem_lane_align.

Verification
REQ-024 Word store, WaitStates=0: wdata addr 0x10, data 0xDEADBEEF, strb 1111 -> ready at k; mem_en/we at k+1 with mem_addr 4, be 1111; wdata_valid at k+3.
REQ-025 Byte load: SRAM word 1 = 0x11223344, rdata addr 0x06, strb 0001 -> mem_be 0100; rdata_data_o = 0x00000022, valid at k+3.
REQ-026 Misaligned halfword: addr 0x03, strb 0011 -> no mem_en; valid with data 0 and dmem_err_o=1; also addr 4*MemWords -> error.
REQ-027 Simultaneous requests: store then load to the same address 0x20 -> store served first; the load returns the stored data.
REQ-028 WaitStates=3: mem_en at k+4, valid at k+6; rst_i asserted in WAIT -> no valid, no mem_en, all outputs 0 next cycle.

Source files
------------

// File: rtl/beta_pkg.sv
// Shared types for the data-memory controller: FSM state encoding and a
// width helper used by the interface and the controller.
package beta_pkg;

    localparam int dmem_fsm_bsize = 2;

    typedef enum logic [dmem_fsm_bsize-1:0] {
        DMEM_IDLE = 2'd0,
        DMEM_WAIT = 2'd1,
        DMEM_MEM  = 2'd2,
        DMEM_RESP = 2'd3
    } dmem_state_e;

    function automatic int unsigned clog2_min1(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/beta_dmem_ctrl_if.sv
// Load/store request channels plus the SRAM port of the data-memory controller.
// The controller uses the slave view; a CPU/SRAM model uses the master view.
interface beta_dmem_ctrl_if
    import beta_pkg::*;
#(
    parameter int DataWidth    = 32,
    parameter int AddressWidth = 32,
    parameter int MemWords     = 1024
);
    localparam int MemAw = clog2_min1(MemWords);

    logic                    rdata_req_i;
    logic [AddressWidth-1:0] rdata_addr_i;
    logic [3:0]              rdata_strb_i;
    logic                    rdata_ready_o;
    logic                    rdata_valid_o;
    logic [DataWidth-1:0]    rdata_data_o;
    logic                    wdata_req_i;
    logic [AddressWidth-1:0] wdata_addr_i;
    logic [DataWidth-1:0]    wdata_data_i;
    logic [3:0]              wdata_strb_i;
    logic                    wdata_ready_o;
    logic                    wdata_valid_o;
    logic                    dmem_err_o;
    logic                    mem_en_o;
    logic                    mem_we_o;
    logic [MemAw-1:0]        mem_addr_o;
    logic [3:0]              mem_be_o;
    logic [DataWidth-1:0]    mem_wdata_o;
    logic [DataWidth-1:0]    mem_rdata_i;

    modport slave (
        input  rdata_req_i, rdata_addr_i, rdata_strb_i,
        output rdata_ready_o, rdata_valid_o, rdata_data_o,
        input  wdata_req_i, wdata_addr_i, wdata_data_i, wdata_strb_i,
        output wdata_ready_o, wdata_valid_o, dmem_err_o,
        output mem_en_o, mem_we_o, mem_addr_o, mem_be_o, mem_wdata_o,
        input  mem_rdata_i
    );

    modport master (
        output rdata_req_i, rdata_addr_i, rdata_strb_i,
        input  rdata_ready_o, rdata_valid_o, rdata_data_o,
        output wdata_req_i, wdata_addr_i, wdata_data_i, wdata_strb_i,
        input  wdata_ready_o, wdata_valid_o, dmem_err_o,
        input  mem_en_o, mem_we_o, mem_addr_o, mem_be_o, mem_wdata_o,
        output mem_rdata_i
    );

endinterface

// File: rtl/beta_dmem_lane_align.sv
// Combinational byte-lane steering between a right-aligned CPU datum and a
// word-wide SRAM, plus the access-error check (lane overflow or out of range).
module beta_dmem_lane_align #(
    parameter int DataWidth    = 32,
    parameter int AddressWidth = 32,
    parameter int MemWords     = 1024,
    parameter int MemAw        = 10
) (
    input  logic [AddressWidth-1:0] i_addr,
    input  logic [3:0]              i_strb,
    input  logic [DataWidth-1:0]    i_wdata,
    input  logic [DataWidth-1:0]    i_mem_rdata,
    output logic                    o_err,
    output logic [MemAw-1:0]        o_word_addr,
    output logic [3:0]              o_be,
    output logic [DataWidth-1:0]    o_wdata,
    output logic [DataWidth-1:0]    o_rdata
);
    logic [1:0]              w_off;
    logic [6:0]              w_lanes;
    logic [AddressWidth-1:0] w_word;
    logic [DataWidth-1:0]    w_rshift;

    assign w_off   = i_addr[1:0];
    assign w_lanes = {3'b000, i_strb} << w_off;
    assign w_word  = i_addr >> 2;

    // Any lane pushed past lane 3 means the access straddles a word boundary.
    assign o_err       = (|w_lanes[6:4]) || (w_word >= AddressWidth'(MemWords));
    assign o_word_addr = w_word[MemAw-1:0];
    assign o_be        = w_lanes[3:0];
    assign o_wdata     = i_wdata << {w_off, 3'b000};
    assign w_rshift    = i_mem_rdata >> {w_off, 3'b000};

    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_lane
            assign o_rdata[8*gi +: 8] = i_strb[gi] ? w_rshift[8*gi +: 8] : 8'h00;
        end
    endgenerate

endmodule

// File: rtl/beta_dmem_ctrl.sv
// Single-outstanding data-memory controller: arbitrates load/store requests,
// inserts optional wait states and performs one SRAM access per transaction.
module beta_dmem_ctrl
    import beta_pkg::*;
#(
    parameter int DataWidth    = 32,
    parameter int AddressWidth = 32,
    parameter int WaitStates   = 0,
    parameter int MemWords     = 1024
) (
    input  logic             clk_i,
    input  logic             rst_i,
    beta_dmem_ctrl_if.slave  bus
);
    localparam int MemAw = clog2_min1(MemWords);
    localparam int CntW  = clog2_min1(WaitStates + 1);

    dmem_state_e             r_state;
    dmem_state_e             w_state_next;
    logic                    r_is_store;
    logic [AddressWidth-1:0] r_addr;
    logic [3:0]              r_strb;
    logic [DataWidth-1:0]    r_wdata;
    logic [CntW-1:0]         r_cnt;
    logic                    r_rready, r_wready, r_rvalid, r_wvalid, r_err;
    logic [DataWidth-1:0]    r_rdata;

    logic                    w_accept_store, w_accept_load, w_err;
    logic [MemAw-1:0]        w_mem_addr;
    logic [3:0]              w_mem_be;
    logic [DataWidth-1:0]    w_mem_wdata, w_load_data;

    // Stores win when both channels request in the same cycle.
    assign w_accept_store = (r_state == DMEM_IDLE) && bus.wdata_req_i;
    assign w_accept_load  = (r_state == DMEM_IDLE) && bus.rdata_req_i && !bus.wdata_req_i;

    beta_dmem_lane_align #(
        .DataWidth    (DataWidth),
        .AddressWidth (AddressWidth),
        .MemWords     (MemWords),
        .MemAw        (MemAw)
    ) u_align (
        .i_addr      (r_addr),
        .i_strb      (r_strb),
        .i_wdata     (r_wdata),
        .i_mem_rdata (bus.mem_rdata_i),
        .o_err       (w_err),
        .o_word_addr (w_mem_addr),
        .o_be        (w_mem_be),
        .o_wdata     (w_mem_wdata),
        .o_rdata     (w_load_data)
    );

    always_ff @(posedge clk_i) begin
        if (rst_i) r_state <= DMEM_IDLE;
        else       r_state <= w_state_next;
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            DMEM_IDLE: if (w_accept_store || w_accept_load) w_state_next = DMEM_WAIT;
            DMEM_WAIT: if (r_cnt == '0) w_state_next = w_err ? DMEM_RESP : DMEM_MEM;
            DMEM_MEM:  w_state_next = DMEM_RESP;
            DMEM_RESP: w_state_next = DMEM_IDLE;
            default:   w_state_next = DMEM_IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_is_store <= 1'b0;
            r_addr     <= '0;
            r_strb     <= '0;
            r_wdata    <= '0;
            r_cnt      <= '0;
            r_rready   <= 1'b0;
            r_wready   <= 1'b0;
            r_rvalid   <= 1'b0;
            r_wvalid   <= 1'b0;
            r_err      <= 1'b0;
            r_rdata    <= '0;
        end else begin
            r_rready <= 1'b0;
            r_wready <= 1'b0;
            r_rvalid <= 1'b0;
            r_wvalid <= 1'b0;
            r_err    <= 1'b0;
            case (r_state)
                DMEM_IDLE: begin
                    if (w_accept_store || w_accept_load) begin
                        r_is_store <= w_accept_store;
                        r_addr     <= w_accept_store ? bus.wdata_addr_i : bus.rdata_addr_i;
                        r_strb     <= w_accept_store ? bus.wdata_strb_i : bus.rdata_strb_i;
                        r_wdata    <= bus.wdata_data_i;
                        r_cnt      <= CntW'(WaitStates);
                        r_wready   <= w_accept_store;
                        r_rready   <= w_accept_load;
                    end
                end
                DMEM_WAIT: if (r_cnt != '0) r_cnt <= r_cnt - 1'b1;
                DMEM_RESP: begin
                    // SRAM read data arrives this cycle, one after the MEM cycle.
                    r_wvalid <= r_is_store;
                    r_rvalid <= !r_is_store;
                    r_err    <= w_err;
                    if (!r_is_store) r_rdata <= w_err ? '0 : w_load_data;
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        bus.mem_en_o    = 1'b0;
        bus.mem_we_o    = 1'b0;
        bus.mem_addr_o  = '0;
        bus.mem_be_o    = '0;
        bus.mem_wdata_o = '0;
        if (r_state == DMEM_MEM) begin
            bus.mem_en_o    = 1'b1;
            bus.mem_we_o    = r_is_store;
            bus.mem_addr_o  = w_mem_addr;
            bus.mem_be_o    = w_mem_be;
            bus.mem_wdata_o = w_mem_wdata;
        end
    end

    assign bus.rdata_ready_o = r_rready;
    assign bus.wdata_ready_o = r_wready;
    assign bus.rdata_valid_o = r_rvalid;
    assign bus.wdata_valid_o = r_wvalid;
    assign bus.dmem_err_o    = r_err;
    assign bus.rdata_data_o  = r_rdata;

endmodule

// File: tb/tb_beta_dmem_ctrl.sv
// Directed bench for beta_dmem_ctrl: vector table on a zero-wait instance,
// hand sequences for arbitration, wait states and mid-transaction reset.
module tb_beta_dmem_ctrl;

    localparam int MW = 1024;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst0, rst3;
    int   n_checks = 0;
    int   n_pass   = 0;

    beta_dmem_ctrl_if #(.DataWidth(32), .AddressWidth(32), .MemWords(MW)) b0 ();
    beta_dmem_ctrl_if #(.DataWidth(32), .AddressWidth(32), .MemWords(MW)) b3 ();

    beta_dmem_ctrl #(.DataWidth(32), .AddressWidth(32), .WaitStates(0), .MemWords(MW)) dut0 (
        .clk_i (clk), .rst_i (rst0), .bus (b0.slave));
    beta_dmem_ctrl #(.DataWidth(32), .AddressWidth(32), .WaitStates(3), .MemWords(MW)) dut3 (
        .clk_i (clk), .rst_i (rst3), .bus (b3.slave));

    logic [31:0] mem0 [MW];
    logic [31:0] mem3 [MW];

    function automatic logic [31:0] merge(input logic [31:0] old_w, input logic [31:0] new_w,
                                          input logic [3:0] be);
        logic [31:0] t;
        t = old_w;
        for (int i = 0; i < 4; i++) if (be[i]) t[8*i +: 8] = new_w[8*i +: 8];
        return t;
    endfunction

    always @(posedge clk) begin
        if (b0.mem_en_o) begin
            if (b0.mem_we_o) mem0[b0.mem_addr_o] <= merge(mem0[b0.mem_addr_o], b0.mem_wdata_o, b0.mem_be_o);
            else             b0.mem_rdata_i <= mem0[b0.mem_addr_o];
        end
        if (b3.mem_en_o) begin
            if (b3.mem_we_o) mem3[b3.mem_addr_o] <= merge(mem3[b3.mem_addr_o], b3.mem_wdata_o, b3.mem_be_o);
            else             b3.mem_rdata_i <= mem3[b3.mem_addr_o];
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    endtask

    typedef struct {
        logic        is_store;
        logic [31:0] addr;
        logic [31:0] data;
        logic [3:0]  strb;
        logic        err;
        logic [9:0]  maddr;
        logic [3:0]  be;
        logic [31:0] wdata;
        logic [31:0] rdata;
    } vec_t;

    vec_t        vecs [12];
    logic [31:0] last_rdata = 32'h0;

    task automatic do_op(input int idx, input vec_t v);
        int          en_cyc, en_cnt, val_cyc;
        logic        m_we, v_store, v_err;
        logic [9:0]  m_addr;
        logic [3:0]  m_be;
        logic [31:0] m_wd, exp_rd;
        en_cyc = -1; en_cnt = 0; val_cyc = -1;
        m_we = 0; v_store = 0; v_err = 0; m_addr = '0; m_be = '0; m_wd = '0;
        @(negedge clk);
        if (v.is_store) begin
            b0.wdata_req_i = 1'b1; b0.wdata_addr_i = v.addr;
            b0.wdata_data_i = v.data; b0.wdata_strb_i = v.strb;
        end else begin
            b0.rdata_req_i = 1'b1; b0.rdata_addr_i = v.addr; b0.rdata_strb_i = v.strb;
        end
        @(negedge clk);
        check($sformatf("v%0d ready", idx), {31'b0, v.is_store ? b0.wdata_ready_o : b0.rdata_ready_o}, 32'd1);
        check($sformatf("v%0d other ready", idx), {31'b0, v.is_store ? b0.rdata_ready_o : b0.wdata_ready_o}, 32'd0);
        b0.wdata_req_i = 1'b0;
        b0.rdata_req_i = 1'b0;
        for (int n = 1; n <= 6; n++) begin
            @(negedge clk);
            if (b0.mem_en_o) begin
                en_cnt++;
                if (en_cyc < 0) begin
                    en_cyc = n; m_we = b0.mem_we_o; m_addr = b0.mem_addr_o;
                    m_be = b0.mem_be_o; m_wd = b0.mem_wdata_o;
                end
            end
            if ((b0.wdata_valid_o || b0.rdata_valid_o) && val_cyc < 0) begin
                val_cyc = n; v_store = b0.wdata_valid_o; v_err = b0.dmem_err_o;
            end
        end
        exp_rd = v.is_store ? last_rdata : (v.err ? 32'h0 : v.rdata);
        check($sformatf("v%0d mem_en count", idx), en_cnt, v.err ? 0 : 1);
        check($sformatf("v%0d valid cycle", idx), val_cyc, v.err ? 2 : 3);
        check($sformatf("v%0d valid channel", idx), {31'b0, v_store}, {31'b0, v.is_store});
        check($sformatf("v%0d err", idx), {31'b0, v_err}, {31'b0, v.err});
        check($sformatf("v%0d rdata", idx), b0.rdata_data_o, exp_rd);
        if (!v.err) begin
            check($sformatf("v%0d mem_en cycle", idx), en_cyc, 1);
            check($sformatf("v%0d mem_we", idx), {31'b0, m_we}, {31'b0, v.is_store});
            check($sformatf("v%0d mem_addr", idx), {22'b0, m_addr}, {22'b0, v.maddr});
            check($sformatf("v%0d mem_be", idx), {28'b0, m_be}, {28'b0, v.be});
            if (v.is_store) check($sformatf("v%0d mem_wdata", idx), m_wd, v.wdata);
        end
        last_rdata = exp_rd;
        $display("vec %0d: %s addr=0x%08h strb=%b err=%0d rdata=0x%08h",
                 idx, v.is_store ? "store" : "load ", v.addr, v.strb, v_err, b0.rdata_data_o);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        int          wr, rr, w_first, r_first, rv, en_cyc, val_cyc, en_cnt, v_cnt;
        logic [31:0] rd;

        for (int i = 0; i < MW; i++) begin mem0[i] = 32'h0; mem3[i] = 32'h0; end
        vecs[0]  = '{1'b1, 32'h10,   32'hDEADBEEF, 4'hF, 1'b0, 10'd4,    4'hF, 32'hDEADBEEF, 32'h0};
        vecs[1]  = '{1'b1, 32'h04,   32'h11223344, 4'hF, 1'b0, 10'd1,    4'hF, 32'h11223344, 32'h0};
        vecs[2]  = '{1'b0, 32'h06,   32'h0,        4'h1, 1'b0, 10'd1,    4'h4, 32'h0, 32'h00000022};
        vecs[3]  = '{1'b0, 32'h06,   32'h0,        4'h3, 1'b0, 10'd1,    4'hC, 32'h0, 32'h00001122};
        vecs[4]  = '{1'b0, 32'h10,   32'h0,        4'hF, 1'b0, 10'd4,    4'hF, 32'h0, 32'hDEADBEEF};
        vecs[5]  = '{1'b1, 32'h11,   32'h000000AB, 4'h1, 1'b0, 10'd4,    4'h2, 32'h0000AB00, 32'h0};
        vecs[6]  = '{1'b0, 32'h10,   32'h0,        4'hF, 1'b0, 10'd4,    4'hF, 32'h0, 32'hDEADABEF};
        vecs[7]  = '{1'b1, 32'h1000, 32'h12345678, 4'hF, 1'b1, 10'd0,    4'h0, 32'h0, 32'h0};
        vecs[8]  = '{1'b0, 32'h03,   32'h0,        4'h3, 1'b1, 10'd0,    4'h0, 32'h0, 32'h0};
        vecs[9]  = '{1'b0, 32'h13,   32'h0,        4'h1, 1'b0, 10'd4,    4'h8, 32'h0, 32'h000000DE};
        vecs[10] = '{1'b1, 32'hFFC,  32'hCAFEF00D, 4'hF, 1'b0, 10'd1023, 4'hF, 32'hCAFEF00D, 32'h0};
        vecs[11] = '{1'b0, 32'hFFE,  32'h0,        4'h3, 1'b0, 10'd1023, 4'hC, 32'h0, 32'h0000CAFE};

        rst0 = 1'b1; rst3 = 1'b1;
        b0.rdata_req_i = 0; b0.rdata_addr_i = 0; b0.rdata_strb_i = 0;
        b0.wdata_req_i = 0; b0.wdata_addr_i = 0; b0.wdata_data_i = 0; b0.wdata_strb_i = 0;
        b3.rdata_req_i = 0; b3.rdata_addr_i = 0; b3.rdata_strb_i = 0;
        b3.wdata_req_i = 0; b3.wdata_addr_i = 0; b3.wdata_data_i = 0; b3.wdata_strb_i = 0;
        repeat (3) @(negedge clk);
        rst0 = 1'b0; rst3 = 1'b0;
        @(negedge clk);
        check("reset rdata", b0.rdata_data_o, 32'h0);
        check("reset ctrl outputs", {26'b0, b0.rdata_ready_o, b0.rdata_valid_o, b0.wdata_ready_o,
              b0.wdata_valid_o, b0.dmem_err_o, b0.mem_en_o}, 32'h0);
        $display("reset: outputs rdata=0x%08h en=%0d", b0.rdata_data_o, b0.mem_en_o);

        for (int i = 0; i < 12; i++) do_op(i, vecs[i]);

        // Simultaneous store and load to 0x20; store req held through its ready cycle.
        wr = 0; rr = 0; w_first = -1; r_first = -1; rv = -1; rd = 32'h0;
        @(negedge clk);
        b0.wdata_req_i = 1'b1; b0.wdata_addr_i = 32'h20; b0.wdata_data_i = 32'h5A5AA5A5; b0.wdata_strb_i = 4'hF;
        b0.rdata_req_i = 1'b1; b0.rdata_addr_i = 32'h20; b0.rdata_strb_i = 4'hF;
        for (int n = 0; n < 15; n++) begin
            @(negedge clk);
            if (b0.wdata_ready_o) begin wr++; if (w_first < 0) w_first = n; end
            if (b0.rdata_ready_o) begin rr++; if (r_first < 0) r_first = n; b0.rdata_req_i = 1'b0; end
            if (n == 1) b0.wdata_req_i = 1'b0;
            if (b0.rdata_valid_o && rv < 0) begin rv = n; rd = b0.rdata_data_o; end
        end
        check("simul store ready cycle", w_first, 0);
        check("simul store ready count", wr, 1);
        check("simul load ready cycle", r_first, 4);
        check("simul load ready count", rr, 1);
        check("simul load valid cycle", rv, 7);
        check("simul load data", rd, 32'h5A5AA5A5);
        $display("simul: store then load @0x20 rdata=0x%08h", rd);

        // WaitStates=3 store.
        en_cyc = -1; val_cyc = -1;
        @(negedge clk);
        b3.wdata_req_i = 1'b1; b3.wdata_addr_i = 32'h8; b3.wdata_data_i = 32'h12345678; b3.wdata_strb_i = 4'hF;
        @(negedge clk);
        check("ws3 store ready", {31'b0, b3.wdata_ready_o}, 32'd1);
        b3.wdata_req_i = 1'b0;
        for (int n = 1; n <= 9; n++) begin
            @(negedge clk);
            if (b3.mem_en_o && en_cyc < 0) en_cyc = n;
            if (b3.wdata_valid_o && val_cyc < 0) val_cyc = n;
        end
        check("ws3 store mem_en cycle", en_cyc, 4);
        check("ws3 store valid cycle", val_cyc, 6);
        check("ws3 sram word 2", mem3[2], 32'h12345678);
        $display("ws3: store @0x8 en=k+%0d valid=k+%0d", en_cyc, val_cyc);

        // WaitStates=3 load back.
        val_cyc = -1;
        @(negedge clk);
        b3.rdata_req_i = 1'b1; b3.rdata_addr_i = 32'h8; b3.rdata_strb_i = 4'hF;
        @(negedge clk);
        b3.rdata_req_i = 1'b0;
        for (int n = 1; n <= 9; n++) begin
            @(negedge clk);
            if (b3.rdata_valid_o && val_cyc < 0) val_cyc = n;
        end
        check("ws3 load valid cycle", val_cyc, 6);
        check("ws3 load data", b3.rdata_data_o, 32'h12345678);
        $display("ws3: load @0x8 rdata=0x%08h", b3.rdata_data_o);

        // Reset while in WAIT drops the store.
        @(negedge clk);
        b3.wdata_req_i = 1'b1; b3.wdata_addr_i = 32'hC; b3.wdata_data_i = 32'hA5A5A5A5; b3.wdata_strb_i = 4'hF;
        @(negedge clk);
        b3.wdata_req_i = 1'b0;
        @(negedge clk);
        rst3 = 1'b1;
        @(negedge clk);
        check("ws3 reset rdata", b3.rdata_data_o, 32'h0);
        check("ws3 reset ctrl outputs", {26'b0, b3.rdata_ready_o, b3.rdata_valid_o, b3.wdata_ready_o,
              b3.wdata_valid_o, b3.dmem_err_o, b3.mem_en_o}, 32'h0);
        check("ws3 reset mem bus", {b3.mem_we_o, b3.mem_be_o, b3.mem_addr_o} ^ b3.mem_wdata_o[14:0], 15'h0);
        rst3 = 1'b0;
        en_cnt = 0; v_cnt = 0;
        for (int n = 0; n < 10; n++) begin
            @(negedge clk);
            if (b3.mem_en_o) en_cnt++;
            if (b3.wdata_valid_o || b3.rdata_valid_o) v_cnt++;
        end
        check("ws3 reset no mem_en", en_cnt, 0);
        check("ws3 reset no valid", v_cnt, 0);
        check("ws3 reset sram word 3", mem3[3], 32'h0);
        $display("ws3: reset in WAIT en=%0d valid=%0d", en_cnt, v_cnt);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
